// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: display scan lines in, recovered value out
interface seg7_scan_decoder_if;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic [12:0] num;
  logic [15:0] digits;
  logic        valid;
  logic        err;
  logic        ovf;
  modport master (output anode, seg, input num, digits, valid, err, ovf);
  modport slave  (input anode, seg, output num, digits, valid, err, ovf);
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers a scanned 4-digit 7-seg value as BCD and binary; SEG7_DEC_BLANK_EN decodes a dark digit as 0
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_FRAMES = 2
) (
  input logic clk,
  input logic rst_n,
  seg7_scan_decoder_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2;
  localparam logic [19:0] NO_FRAME = {16'h0000, 4'hf};
  logic [3:0] an_q, an_d, an_p_q, an_p_d, inv_q, inv_d, mask_q, mask_d;
  logic [6:0] sg_q, sg_d, sg_p_q, sg_p_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [15:0] dig_q, dig_d, snap_q, snap_d, pend_q, pend_d, digits_q, digits_d;
  logic [19:0] prev_q, prev_d, last_q, last_d, frame;
  logic [MW-1:0] match_q, match_d;
  logic [1:0] st_q, st_d, step_q, step_d, slot;
  logic [13:0] acc_q, acc_d, mac;
  logic [12:0] num_q, num_d;
  logic pend_v_q, pend_v_d, valid_q, valid_d, err_q, err_d, ovf_q, ovf_d;
  logic legal, changed, cap, full, f_bad, req, start, done;
  logic [4:0] dec;
  logic [3:0] cur;
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: return 5'h00;
      7'b1001111: return 5'h01;
      7'b0010010: return 5'h02;
      7'b0000110: return 5'h03;
      7'b1001100: return 5'h04;
      7'b0100100: return 5'h05;
      7'b0100000: return 5'h06;
      7'b0001111: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0000100: return 5'h09;
`ifdef SEG7_DEC_BLANK_EN
      7'b1111111: return 5'h00;
`else
`endif
      default:    return 5'h10;
    endcase
  endfunction
  always_comb begin
    an_d = bus.anode;
    sg_d = bus.seg;
    an_p_d = an_q;
    sg_p_d = sg_q;
    legal = an_q inside {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    slot = an_q == 4'b0111 ? 2'd3 : an_q == 4'b1011 ? 2'd2 : an_q == 4'b1101 ? 2'd1 : 2'd0;
    changed = {an_q, sg_q} != {an_p_q, sg_p_q};
    settle_d = (changed || !legal) ? '0 : settle_q == SW'(SETTLE_CYCLES) ? settle_q : settle_q + 1'b1;
    cap = !changed && legal && settle_q == SW'(SETTLE_CYCLES - 1);
    dec = decode(sg_q);
    full = &mask_q;
    frame = {dig_q, inv_q};
    f_bad = |inv_q;
    dig_d = dig_q;
    inv_d = inv_q;
    mask_d = full ? 4'h0 : mask_q;
    if (cap) begin
      dig_d[{slot, 2'b00} +: 4] = dec[3:0];
      inv_d[slot] = dec[4];
      mask_d[slot] = 1'b1;
    end
    prev_d = full ? frame : prev_q;
    match_d = !full ? match_q : f_bad ? '0 : frame != prev_q ? MW'(1) :
              match_q == MW'(STABLE_FRAMES) ? match_q : match_q + 1'b1;
    req = full && !f_bad && match_d == MW'(STABLE_FRAMES) && frame != last_q;
    last_d = req ? frame : last_q;
    err_d = full && f_bad;
    // a request that lands mid-conversion waits here for the next IDLE
    start = st_q == IDLE && (req || pend_v_q);
    pend_v_d = req && st_q != IDLE ? 1'b1 : start ? 1'b0 : pend_v_q;
    pend_d = req && st_q != IDLE ? dig_q : pend_q;
    snap_d = start ? (req ? dig_q : pend_q) : snap_q;
    cur = step_q == 2'd0 ? snap_q[15:12] : step_q == 2'd1 ? snap_q[11:8] :
          step_q == 2'd2 ? snap_q[7:4] : snap_q[3:0];
    mac = (acc_q << 3) + (acc_q << 1) + {10'd0, cur};
    acc_d = start ? '0 : st_q == CONV ? mac : acc_q;
    step_d = start ? 2'd0 : st_q == CONV ? step_q + 2'd1 : step_q;
    st_d = start ? CONV : st_q == CONV && step_q == 2'd3 ? DONE : st_q == DONE ? IDLE : st_q;
    done = st_q == DONE;
    valid_d = done && !acc_q[13];
    num_d = valid_d ? acc_q[12:0] : num_q;
    digits_d = valid_d ? snap_q : digits_q;
    ovf_d = done ? acc_q[13] : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      an_q <= 4'hf;
      sg_q <= 7'h7f;
      an_p_q <= 4'hf;
      sg_p_q <= 7'h7f;
      settle_q <= '0;
      dig_q <= '0;
      inv_q <= '0;
      mask_q <= '0;
      prev_q <= NO_FRAME;
      last_q <= NO_FRAME;
      match_q <= '0;
      pend_v_q <= 1'b0;
      pend_q <= '0;
      snap_q <= '0;
      acc_q <= '0;
      step_q <= '0;
      st_q <= IDLE;
      num_q <= '0;
      digits_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      an_q <= an_d;
      sg_q <= sg_d;
      an_p_q <= an_p_d;
      sg_p_q <= sg_p_d;
      settle_q <= settle_d;
      dig_q <= dig_d;
      inv_q <= inv_d;
      mask_q <= mask_d;
      prev_q <= prev_d;
      last_q <= last_d;
      match_q <= match_d;
      pend_v_q <= pend_v_d;
      pend_q <= pend_d;
      snap_q <= snap_d;
      acc_q <= acc_d;
      step_q <= step_d;
      st_q <= st_d;
      num_q <= num_d;
      digits_q <= digits_d;
      valid_q <= valid_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  assign bus.num = num_q;
  assign bus.digits = digits_q;
  assign bus.valid = valid_q;
  assign bus.err = err_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed frame vectors plus timing, reset and short-dwell sequences
module tb_seg7_scan_decoder;
  logic clk, rst_n;
  int checks = 0, errors = 0, vcnt = 0, ecnt = 0;
  seg7_scan_decoder_if bus();
  seg7_scan_decoder #(.SETTLE_CYCLES(4), .STABLE_FRAMES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk)
    if (rst_n) begin
      if (bus.valid) vcnt++;
      if (bus.err) ecnt++;
    end
  logic [6:0] seg_lut [10];
  logic [3:0] an_lut [4];
  localparam logic [6:0] BLANK = 7'b1111111, BAD = 7'b1111110;
`ifdef SEG7_DEC_BLANK_EN
  localparam int BV = 1, BE = 0, BN = 42;
  localparam logic [15:0] BD = 16'h0042;
`else
  localparam int BV = 0, BE = 2, BN = 8191;
  localparam logic [15:0] BD = 16'h8191;
`endif
  typedef struct {
    logic [27:0] segs;
    int frames;
    int dwell;
    int exp_valid;
    int exp_err;
    int exp_num;
    logic [15:0] exp_dig;
    int exp_ovf;
  } vec_t;
  vec_t vec [7];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [27:0] f4(input int a, input int b, input int c, input int d);
    return {seg_lut[a], seg_lut[b], seg_lut[c], seg_lut[d]};
  endfunction
  task automatic scan_frame(input logic [27:0] s, input int dwell);
    for (int k = 0; k < 4; k++) begin
      bus.anode = an_lut[k];
      bus.seg = s[27 - 7 * k -: 7];
      repeat (dwell) @(negedge clk);
    end
  endtask
  task automatic idle(input int n);
    bus.anode = 4'hf;
    bus.seg = 7'h7f;
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_num"}, int'(bus.num), 0);
    chk({tag, "_digits"}, int'(bus.digits), 0);
    chk({tag, "_valid"}, int'(bus.valid), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_ovf"}, int'(bus.ovf), 0);
  endtask
  initial begin
    int v0, e0;
    seg_lut = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    an_lut = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    vec[0] = '{f4(1, 2, 3, 4), 5, 6, 0, 0, 1234, 16'h1234, 0};
    vec[1] = '{f4(0, 0, 4, 2), 2, 6, 1, 0, 42, 16'h0042, 0};
    vec[2] = '{f4(9, 9, 9, 9), 2, 6, 0, 0, 42, 16'h0042, 1};
    vec[3] = '{f4(8, 1, 9, 1), 2, 6, 1, 0, 8191, 16'h8191, 0};
    vec[4] = '{{seg_lut[1], seg_lut[2], BAD, seg_lut[4]}, 2, 6, 0, 2, 8191, 16'h8191, 0};
    vec[5] = '{{BLANK, seg_lut[0], seg_lut[4], seg_lut[2]}, 2, 6, BV, BE, BN, BD, 0};
    vec[6] = '{f4(5, 6, 7, 8), 3, 3, 0, 0, BN, BD, 0};
    rst_n = 1'b0;
    bus.anode = 4'hf;
    bus.seg = 7'h7f;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.anode = an_lut[i];
      bus.seg = seg_lut[i + 3];
      chk_zero($sformatf("rst%0d", i));
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero("rel");
    idle(3);
    scan_frame(f4(1, 2, 3, 4), 6);
    scan_frame(f4(1, 2, 3, 4), 6);
    bus.anode = 4'hf;
    bus.seg = 7'h7f;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("t_early%0d", i), int'(bus.valid), 0);
    end
    @(negedge clk);
    chk("t_valid", int'(bus.valid), 1);
    chk("t_num", int'(bus.num), 1234);
    chk("t_digits", int'(bus.digits), 16'h1234);
    @(negedge clk);
    chk("t_pulse", int'(bus.valid), 0);
    chk("t_vcnt", vcnt, 1);
    idle(4);
    for (int i = 0; i < 7; i++) begin
      v0 = vcnt;
      e0 = ecnt;
      for (int f = 0; f < vec[i].frames; f++) scan_frame(vec[i].segs, vec[i].dwell);
      idle(12);
      chk($sformatf("v%0d_valid", i), vcnt - v0, vec[i].exp_valid);
      chk($sformatf("v%0d_err", i), ecnt - e0, vec[i].exp_err);
      chk($sformatf("v%0d_num", i), int'(bus.num), vec[i].exp_num);
      chk($sformatf("v%0d_digits", i), int'(bus.digits), int'(vec[i].exp_dig));
      chk($sformatf("v%0d_ovf", i), int'(bus.ovf), vec[i].exp_ovf);
    end
    v0 = vcnt;
    scan_frame(f4(7, 7, 7, 7), 6);
    scan_frame(f4(7, 7, 7, 7), 6);
    bus.anode = 4'hf;
    bus.seg = 7'h7f;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("rc");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(12);
    chk("rc_vcnt", vcnt - v0, 0);
    chk_zero("rc_after");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
